// File: rtl/sigma_rms_scheduler_if.sv
// Request/response bundle between RMS producers and the shared div/sqrt scheduler.
// req/gnt handshake: a producer holds i_req[k] and its i_num/i_den slots stable until it sees o_gnt[k]; the transfer happens on the edge where both are high, and i_req[k] still high after that edge is a new request.
interface sigma_rms_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int NUM_W   = 32,
  parameter int DEN_W   = 12,
  parameter int ID_W    = 1
) ();
  localparam int RW = NUM_W / 2;

  logic [NUM_REQ-1:0]       i_req;
  logic [NUM_REQ*NUM_W-1:0] i_num;
  logic [NUM_REQ*DEN_W-1:0] i_den;
  logic                     i_flush;
  logic [NUM_REQ-1:0]       o_gnt;
  logic                     o_rsp_valid;
  logic [ID_W-1:0]          o_rsp_id;
  logic [RW-1:0]            o_rsp_root;
  logic                     o_rsp_err;
  logic [NUM_REQ*RW-1:0]    o_result;
  logic [NUM_REQ-1:0]       o_done;
  logic                     o_busy;

  modport master (
    output i_req, i_num, i_den, i_flush,
    input  o_gnt, o_rsp_valid, o_rsp_id, o_rsp_root, o_rsp_err, o_result, o_done, o_busy
  );

  modport slave (
    input  i_req, i_num, i_den, i_flush,
    output o_gnt, o_rsp_valid, o_rsp_id, o_rsp_root, o_rsp_err, o_result, o_done, o_busy
  );
endinterface

// File: rtl/sigma_rms_scheduler.sv
// Round-robin scheduler sharing one pipelined divide -> square-root datapath among
// NUM_REQ RMS producers; each result is floor(sqrt(floor(num/den))), 5 edges after grant.
module sigma_rms_scheduler #(
  parameter int NUM_REQ   = 2,
  parameter int CLOUD_BW  = 8,
  parameter int H_SIZE_BW = 6,
  parameter int V_SIZE_BW = 6,
  parameter int NUM_W     = 4 * CLOUD_BW,
  parameter int DEN_W     = H_SIZE_BW + V_SIZE_BW,
  parameter int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  sigma_rms_scheduler_if.slave  bus
);

  localparam int RW = NUM_W / 2;
  localparam int SB = 4;

  // Arbitration
  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic [ID_W-1:0]    idx;
  logic [NUM_W-1:0]   sel_num;
  logic [DEN_W-1:0]   sel_den;

  // Issue register and sideband pipeline
  logic               iss_valid;
  logic [ID_W-1:0]    iss_id;
  logic               iss_err;
  logic [NUM_W-1:0]   iss_num;
  logic [DEN_W-1:0]   iss_den;
  logic [SB-1:0]      sb_valid;
  logic [SB-1:0]      sb_err;
  logic [ID_W-1:0]    sb_id [SB];

  // Datapath stages
  logic [NUM_W-1:0]   div_num;
  logic [NUM_W-1:0]   div_den;
  logic [NUM_W-1:0]   quot_d;
  logic [NUM_W-1:0]   quot_q;
  logic [NUM_W-1:0]   sq_in;
  logic [RW-1:0]      root_d;
  logic [RW-1:0]      root_q;

  // Output registers
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [RW-1:0]      rsp_root_q;
  logic               rsp_err_q;
  logic [NUM_REQ*RW-1:0] result_q;
  logic [NUM_REQ-1:0] done_q;

  function automatic logic [RW-1:0] isqrt(input logic [NUM_W-1:0] v);
    logic [RW+1:0] rem;
    logic [RW+1:0] trial;
    logic [RW-1:0] root;
    rem   = '0;
    trial = '0;
    root  = '0;
    for (int i = RW - 1; i >= 0; i--) begin
      rem   = {rem[RW-1:0], v[2*i +: 2]};
      trial = {root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[RW-2:0], 1'b1};
      end else begin
        root = {root[RW-2:0], 1'b0};
      end
    end
    return root;
  endfunction

  // First requester at or above the pointer (with wrap) wins; flush suppresses every grant.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!gnt_any && !bus.i_flush && bus.i_req[idx]) begin
        gnt_any  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  always_comb begin
    sel_num = '0;
    sel_den = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_num = bus.i_num[i*NUM_W +: NUM_W];
        sel_den = bus.i_den[i*DEN_W +: DEN_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      iss_valid <= 1'b0;
      iss_id    <= '0;
      iss_err   <= 1'b0;
      iss_num   <= '0;
      iss_den   <= '0;
      sb_valid  <= '0;
      sb_err    <= '0;
      for (int i = 0; i < SB; i++) sb_id[i] <= '0;
    end else begin
      if (gnt_any) begin
        iss_id  <= gnt_id;
        iss_err <= (sel_den == '0) | sel_num[NUM_W-1];
        iss_num <= sel_num;
        iss_den <= sel_den;
      end
      sb_err <= {sb_err[SB-2:0], iss_err};
      sb_id[0] <= iss_id;
      for (int i = 1; i < SB; i++) sb_id[i] <= sb_id[i-1];
      if (bus.i_flush) begin
        iss_valid <= 1'b0;
        sb_valid  <= '0;
      end else begin
        iss_valid <= gnt_any;
        sb_valid  <= {sb_valid[SB-2:0], iss_valid};
      end
    end
  end

  // Error operands are replaced by 0/1 so the divider never sees a zero divisor.
  assign quot_d = div_num / div_den;
  assign root_d = isqrt(sq_in);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_num <= '0;
      div_den <= NUM_W'(1);
      quot_q  <= '0;
      sq_in   <= '0;
      root_q  <= '0;
    end else begin
      div_num <= iss_err ? '0 : iss_num;
      div_den <= iss_err ? NUM_W'(1) : NUM_W'(iss_den);
      quot_q  <= quot_d;
      sq_in   <= quot_q;
      root_q  <= root_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_root_q  <= '0;
      rsp_err_q   <= 1'b0;
      result_q    <= '0;
      done_q      <= '0;
    end else begin
      rsp_valid_q <= sb_valid[SB-1] & ~bus.i_flush;
      done_q      <= '0;
      if (sb_valid[SB-1] && !bus.i_flush) begin
        rsp_id_q   <= sb_id[SB-1];
        rsp_root_q <= sb_err[SB-1] ? '0 : root_q;
        rsp_err_q  <= sb_err[SB-1];
        for (int i = 0; i < NUM_REQ; i++) begin
          if (sb_id[SB-1] == ID_W'(i)) begin
            result_q[i*RW +: RW] <= sb_err[SB-1] ? '0 : root_q;
            done_q[i]            <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.o_gnt       = gnt;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_id    = rsp_id_q;
  assign bus.o_rsp_root  = rsp_root_q;
  assign bus.o_rsp_err   = rsp_err_q;
  assign bus.o_result    = result_q;
  assign bus.o_done      = done_q;
  assign bus.o_busy      = iss_valid | (|sb_valid) | rsp_valid_q;

endmodule
